// File: rtl/step_ctrl.sv
// Single-step/run controller: gates soc progress through a registered cpu_en; STEP N yields exactly N enable cycles.
// cpu_en rises the cycle after a command is accepted; while busy only HALT is accepted, other commands stall.
module step_ctrl #(
    parameter int CNT_W         = 32,
    parameter int DEFAULT_STEPS = 100,
    parameter bit START_RUNNING = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             brk,
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       halt_cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam logic [1:0] CAUSE_COUNT = 2'b01;
    localparam logic [1:0] CAUSE_BRK   = 2'b10;
    localparam logic [1:0] CAUSE_HALT  = 2'b11;

    localparam state_t RST_STATE = START_RUNNING ? S_RUN : S_IDLE;
    localparam logic [CNT_W-1:0] DEF_STEPS = CNT_W'(DEFAULT_STEPS);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remaining_nxt;
    logic [1:0]       halt_cause_nxt;
    logic             done_nxt;
    logic             cmd_acc;

    assign busy      = (state != S_IDLE);
    assign cmd_ready = (state == S_IDLE) | (cmd_op == OP_HALT);
    assign cmd_acc   = cmd_valid & cmd_ready;

    // Stop-cause priority on a single edge: HALT command, then breakpoint, then count exhausted.
    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        halt_cause_nxt = halt_cause;
        done_nxt       = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_STEP: begin
                            state_nxt     = S_STEP;
                            remaining_nxt = (cmd_steps == '0) ? DEF_STEPS : cmd_steps;
                        end
                        OP_RUN:  state_nxt = S_RUN;
                        OP_NOP,
                        OP_HALT: state_nxt = S_IDLE;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_STEP, S_RUN: begin
                if (cmd_acc && (cmd_op == OP_HALT)) begin
                    state_nxt      = S_IDLE;
                    remaining_nxt  = '0;
                    halt_cause_nxt = CAUSE_HALT;
                    done_nxt       = 1'b1;
                end else if (brk && cpu_en) begin
                    state_nxt      = S_IDLE;
                    remaining_nxt  = '0;
                    halt_cause_nxt = CAUSE_BRK;
                    done_nxt       = 1'b1;
                end else if (state == S_STEP) begin
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_nxt      = S_IDLE;
                        halt_cause_nxt = CAUSE_COUNT;
                        done_nxt       = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                remaining_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RST_STATE;
            cpu_en      <= START_RUNNING;
            remaining   <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            halt_cause  <= 2'b00;
        end else begin
            state      <= state_nxt;
            cpu_en     <= (state_nxt != S_IDLE);
            remaining  <= remaining_nxt;
            done       <= done_nxt;
            halt_cause <= halt_cause_nxt;
            if (cpu_en) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl: directed scenarios plus random command/breakpoint traffic against a cycle reference model.
module tb_step_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cmd_valid, cmd_ready, brk, cpu_en, busy, done;
    logic [1:0]  cmd_op, halt_cause;
    logic [31:0] cmd_steps, remaining, cycle_count;

    logic        rst2_n, cmd_valid2, cmd_ready2, brk2, cpu_en2, busy2, done2;
    logic [1:0]  cmd_op2, halt_cause2;
    logic [3:0]  cmd_steps2, remaining2, cycle_count2;

    step_ctrl #(.CNT_W(32), .DEFAULT_STEPS(100), .START_RUNNING(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_steps(cmd_steps), .brk(brk), .cpu_en(cpu_en),
        .busy(busy), .done(done), .remaining(remaining), .cycle_count(cycle_count),
        .halt_cause(halt_cause)
    );

    step_ctrl #(.CNT_W(4), .DEFAULT_STEPS(3), .START_RUNNING(1'b1)) dut2 (
        .clk(clk), .rst_n(rst2_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op2), .cmd_steps(cmd_steps2), .brk(brk2), .cpu_en(cpu_en2),
        .busy(busy2), .done(done2), .remaining(remaining2), .cycle_count(cycle_count2),
        .halt_cause(halt_cause2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 stepping with m_left cycles to go, 2 free-running.
    int          m_mode;
    int unsigned m_left;
    logic [31:0] m_cnt;
    bit          m_done;
    logic [1:0]  m_cause;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_cnt = '0; m_done = 0; m_cause = 2'b00;
    endtask

    task automatic model_stop(input logic [1:0] c);
        m_mode = 0; m_left = 0; m_done = 1; m_cause = c;
    endtask

    task automatic check_all(input string w);
        check({w, ".cpu_en"},      cpu_en,      64'(m_mode != 0));
        check({w, ".busy"},        busy,        64'(m_mode != 0));
        check({w, ".done"},        done,        64'(m_done));
        check({w, ".remaining"},   remaining,   64'((m_mode == 1) ? m_left : 0));
        check({w, ".cycle_count"}, cycle_count, 64'(m_cnt));
        check({w, ".halt_cause"},  halt_cause,  64'(m_cause));
    endtask

    // One clock: drive at negedge, predict the edge, compare after it.
    task automatic cyc(input bit v, input logic [1:0] op, input logic [31:0] steps, input bit b);
        bit rdy, acc;
        cmd_valid = v; cmd_op = op; cmd_steps = steps; brk = b;
        #1;
        rdy = (m_mode == 0) || (op == 2'b11);
        check("cmd_ready", cmd_ready, 64'(rdy));
        acc = v && rdy;
        m_done = 0;
        if (m_mode != 0) begin
            m_cnt = m_cnt + 32'd1;
            if (acc && op == 2'b11)   model_stop(2'b11);
            else if (b)               model_stop(2'b10);
            else if (m_mode == 1) begin
                m_left = m_left - 1;
                if (m_left == 0) model_stop(2'b01);
            end
        end else if (acc) begin
            if (op == 2'b01) begin
                m_mode = 1;
                m_left = (steps == 0) ? 100 : steps;
            end else if (op == 2'b10) begin
                m_mode = 2;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; brk = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_steps = '0; brk = 1'b0;
        rst2_n = 1'b0; cmd_valid2 = 1'b0; cmd_op2 = 2'b00; cmd_steps2 = '0; brk2 = 1'b0;
        model_reset();
        #1;
        check_all("por");
        check("por.cmd_ready", cmd_ready, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // STEP 5
        cyc(1'b1, 2'b01, 32'd5, 1'b0);
        check("step5.first_en", cpu_en, 64'd1);
        check("step5.first_rem", remaining, 64'd5);
        idle(5);
        check("step5.done", done, 64'd1);
        check("step5.cc", cycle_count, 64'd5);
        check("step5.cause", halt_cause, 64'd1);
        idle(1);
        check("step5.done_once", done, 64'd0);

        // STEP 0 -> default count
        do_reset();
        cyc(1'b1, 2'b01, 32'd0, 1'b0);
        idle(100);
        check("step0.cc", cycle_count, 64'd100);
        check("step0.cause", halt_cause, 64'd1);
        check("step0.en", cpu_en, 64'd0);

        // RUN, rejected STEP while running, HALT after 10 enabled cycles
        do_reset();
        cyc(1'b1, 2'b10, 32'd0, 1'b0);
        idle(4);
        cyc(1'b1, 2'b01, 32'd3, 1'b0);
        check("run.step_ignored_rem", remaining, 64'd0);
        idle(4);
        cyc(1'b1, 2'b11, 32'd0, 1'b0);
        check("run.cc", cycle_count, 64'd10);
        check("run.cause", halt_cause, 64'd3);
        check("run.en", cpu_en, 64'd0);

        // breakpoint on the 7th enabled cycle of STEP 20, then brk held in IDLE
        do_reset();
        cyc(1'b1, 2'b01, 32'd20, 1'b0);
        idle(6);
        cyc(1'b0, 2'b00, 32'd0, 1'b1);
        check("brk.cc", cycle_count, 64'd7);
        check("brk.rem", remaining, 64'd0);
        check("brk.cause", halt_cause, 64'd2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 32'd0, 1'b1);
        check("brk.idle_en", cpu_en, 64'd0);
        check("brk.idle_cc", cycle_count, 64'd7);

        // HALT and brk together on the last step
        do_reset();
        cyc(1'b1, 2'b01, 32'd3, 1'b0);
        idle(2);
        cyc(1'b1, 2'b11, 32'd0, 1'b1);
        check("prio.cause", halt_cause, 64'd3);
        check("prio.cc", cycle_count, 64'd3);
        check("prio.done", done, 64'd1);
        idle(1);
        check("prio.done_once", done, 64'd0);

        // reset mid-STEP
        do_reset();
        cyc(1'b1, 2'b01, 32'd10, 1'b0);
        idle(2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] s;
            s = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), s,
                $urandom_range(0, 15) == 0);
        end

        // 4-bit counter, start running out of reset, wrap after 18 cycles
        @(negedge clk);
        rst2_n = 1'b1;
        #1;
        check("sr.en_at_release", cpu_en2, 64'd1);
        check("sr.busy_at_release", busy2, 64'd1);
        check("sr.cc_at_release", cycle_count2, 64'd0);
        repeat (17) @(posedge clk);
        @(negedge clk);
        check("sr.cc17", cycle_count2, 64'd1);
        cmd_valid2 = 1'b1; cmd_op2 = 2'b11;
        #1;
        check("sr.halt_ready", cmd_ready2, 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid2 = 1'b0; cmd_op2 = 2'b00;
        check("sr.en", cpu_en2, 64'd0);
        check("sr.cc_wrap", cycle_count2, 64'd2);
        check("sr.cause", halt_cause2, 64'd3);
        check("sr.done", done2, 64'd1);
        check("sr.rem", remaining2, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
